// File: rtl/serial_transmitter.sv
// Parallel-to-serial frame transmitter: start bit (0), DATA_WIDTH data bits LSB first,
// stop bit (1), each bit held CLOCKS_PER_BIT clocks. All outputs are driven from flops.
module serial_transmitter #(
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic                  Valid,
    output logic                  Ready,
    output logic                  Serial,
    output logic                  Busy,
    output logic                  Done
);

    localparam int DIV_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [DIV_W-1:0]        div_r, div_s;
    logic [BIT_W-1:0]        bit_r, bit_s;
    logic [DATA_WIDTH-1:0]   shift_r, shift_s;
    logic [DATA_WIDTH-1:0]   shifted_s;
    logic                    serial_r, serial_s;
    logic                    ready_r, ready_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_s   = state_r;
        div_s     = div_r;
        bit_s     = bit_r;
        shift_s   = shift_r;
        serial_s  = serial_r;
        ready_s   = ready_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        shifted_s = shift_r >> 1;

        case (state_r)
            IDLE: begin
                if (Valid) begin
                    shift_s  = Data;
                    state_s  = START;
                    div_s    = {DIV_W{1'b0}};
                    bit_s    = {BIT_W{1'b0}};
                    ready_s  = 1'b0;
                    busy_s   = 1'b1;
                    serial_s = 1'b0;
                end else begin
                    serial_s = 1'b1;
                    ready_s  = 1'b1;
                    busy_s   = 1'b0;
                end
            end
            START: begin
                if (div_r == DIV_LAST) begin
                    div_s    = {DIV_W{1'b0}};
                    serial_s = shift_r[0];
                    state_s  = DATA;
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            DATA: begin
                if (div_r == DIV_LAST) begin
                    div_s = {DIV_W{1'b0}};
                    if (bit_r == BIT_LAST) begin
                        bit_s    = {BIT_W{1'b0}};
                        serial_s = 1'b1;
                        state_s  = STOP;
                    end else begin
                        // The next data bit is whatever lands in position 0 after the shift.
                        bit_s    = bit_r + BIT_W'(1);
                        shift_s  = shifted_s;
                        serial_s = shifted_s[0];
                    end
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            STOP: begin
                if (div_r == DIV_LAST) begin
                    div_s   = {DIV_W{1'b0}};
                    state_s = IDLE;
                    done_s  = 1'b1;
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            default: begin
                state_s  = IDLE;
                div_s    = {DIV_W{1'b0}};
                bit_s    = {BIT_W{1'b0}};
                serial_s = 1'b1;
                ready_s  = 1'b1;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a Done pulse.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r  <= IDLE;
            div_r    <= {DIV_W{1'b0}};
            bit_r    <= {BIT_W{1'b0}};
            shift_r  <= {DATA_WIDTH{1'b0}};
            serial_r <= 1'b1;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            div_r    <= div_s;
            bit_r    <= bit_s;
            shift_r  <= shift_s;
            serial_r <= serial_s;
            ready_r  <= ready_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign Ready  = ready_r;
    assign Serial = serial_r;
    assign Busy   = busy_r;
    assign Done   = done_r;

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter: default (N=8, C=4) instance plus a
// minimum-parameter (N=1, C=1) instance sharing clock and reset.
module tb_serial_transmitter;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] Data  = 8'h00;
    logic       Valid = 1'b0;
    logic       Ready, Serial, Busy, Done;

    logic       data2  = 1'b0;
    logic       valid2 = 1'b0;
    logic       ready2, serial2, busy2, done2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;     // expected line level per bit slot, slot 0 = start bit
        int         mode;     // 0: Valid dropped, 1: Valid toggled mid-frame
        logic [7:0] corrupt;  // Data value written mid-frame
    } vec_t;

    vec_t vecs[4];

    always #5 Clock = ~Clock;

    serial_transmitter #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Data  (Data),
        .Valid (Valid),
        .Ready (Ready),
        .Serial(Serial),
        .Busy  (Busy),
        .Done  (Done)
    );

    serial_transmitter #(.DATA_WIDTH(1), .CLOCKS_PER_BIT(1)) dut_min (
        .Clock (Clock),
        .Reset (Reset),
        .Data  (data2),
        .Valid (valid2),
        .Ready (ready2),
        .Serial(serial2),
        .Busy  (busy2),
        .Done  (done2)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_serial"}, Serial, 1'b1);
        chk({name, "_ready"},  Ready,  1'b1);
        chk({name, "_busy"},   Busy,   1'b0);
        chk({name, "_done"},   Done,   1'b0);
    endtask

    // Caller drives Valid/Data before calling; this waits for the accepting edge
    // and checks every cycle up to and including the Done cycle.
    task automatic check_body(input logic [9:0] exp_bits, input int mode, input logic [7:0] corrupt);
        @(posedge Clock); #1;
        chk("start_serial", Serial, exp_bits[0]);
        chk("start_ready",  Ready,  1'b0);
        chk("start_busy",   Busy,   1'b1);
        chk("start_done",   Done,   1'b0);
        if (mode != 2) Valid = 1'b0;
        for (int c = 1; c < 40; c++) begin
            if (mode == 1) Valid = c[0];
            if (c == 5) Data = corrupt;
            @(posedge Clock); #1;
            chk($sformatf("bit_serial_c%0d", c), Serial, exp_bits[c / 4]);
            chk($sformatf("bit_ready_c%0d", c),  Ready,  1'b0);
            chk($sformatf("bit_busy_c%0d", c),   Busy,   1'b1);
            chk($sformatf("bit_done_c%0d", c),   Done,   1'b0);
        end
        if (mode == 1) Valid = 1'b0;
        @(posedge Clock); #1;
        chk("end_done",   Done,   1'b1);
        chk("end_ready",  Ready,  1'b1);
        chk("end_busy",   Busy,   1'b0);
        chk("end_serial", Serial, 1'b1);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, bits: 10'b1_1010_0101_0, mode: 0, corrupt: 8'h5A};
        vecs[1] = '{data: 8'h00, bits: 10'b1_0000_0000_0, mode: 1, corrupt: 8'hFF};
        vecs[2] = '{data: 8'hFF, bits: 10'b1_1111_1111_0, mode: 1, corrupt: 8'h00};
        vecs[3] = '{data: 8'h6E, bits: 10'b1_0110_1110_0, mode: 0, corrupt: 8'h91};

        // Reset held with Valid high: nothing may start.
        Valid = 1'b1;
        Data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); #1;
            chk_idle($sformatf("reset_c%0d", i));
            chk("reset_min_serial", serial2, 1'b1);
            chk("reset_min_ready",  ready2,  1'b1);
        end
        Valid = 1'b0;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); #1;
            chk_idle($sformatf("idle_c%0d", i));
        end

        // Table of single frames.
        foreach (vecs[v]) begin
            Valid = 1'b1;
            Data  = vecs[v].data;
            check_body(vecs[v].bits, vecs[v].mode, vecs[v].corrupt);
            @(posedge Clock); #1;
            chk_idle($sformatf("post_frame_v%0d", v));
        end

        // Back-to-back with Valid held high and Data overwritten mid-frame.
        Valid = 1'b1;
        Data  = 8'h3C;
        check_body(10'b1_0011_1100_0, 2, 8'hFF);
        check_body(10'b1_1111_1111_0, 2, 8'hFF);
        Valid = 1'b0;
        @(posedge Clock); #1;
        chk_idle("b2b_after");

        // Asynchronous reset during data bit 3.
        Valid = 1'b1;
        Data  = 8'h55;
        @(posedge Clock); #1;
        Valid = 1'b0;
        repeat (17) @(posedge Clock);
        #1;
        chk("midrst_pre_busy", Busy, 1'b1);
        #3;
        Reset = 1'b0;
        #1;
        chk_idle("midrst_now");
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clock); #1;
            chk_idle($sformatf("midrst_after_c%0d", i));
        end
        Valid = 1'b1;
        Data  = 8'h01;
        check_body(10'b1_0000_0001_0, 0, 8'hAA);
        @(posedge Clock); #1;
        chk_idle("midrst_next_done");

        // Minimum parameters: frame of three one-cycle bits.
        valid2 = 1'b1;
        data2  = 1'b1;
        @(posedge Clock); #1;
        chk("min_start_serial", serial2, 1'b0);
        chk("min_start_busy",   busy2,   1'b1);
        chk("min_start_ready",  ready2,  1'b0);
        valid2 = 1'b0;
        data2  = 1'b0;
        @(posedge Clock); #1;
        chk("min_data_serial", serial2, 1'b1);
        chk("min_data_done",   done2,   1'b0);
        @(posedge Clock); #1;
        chk("min_stop_serial", serial2, 1'b1);
        chk("min_stop_done",   done2,   1'b0);
        chk("min_stop_busy",   busy2,   1'b1);
        @(posedge Clock); #1;
        chk("min_end_done",  done2,  1'b1);
        chk("min_end_ready", ready2, 1'b1);
        chk("min_end_busy",  busy2,  1'b0);
        @(posedge Clock); #1;
        chk("min_after_done", done2, 1'b0);

        // Minimum parameters with a zero data bit.
        valid2 = 1'b1;
        data2  = 1'b0;
        @(posedge Clock); #1;
        valid2 = 1'b0;
        chk("min0_start_serial", serial2, 1'b0);
        @(posedge Clock); #1;
        chk("min0_data_serial", serial2, 1'b0);
        @(posedge Clock); #1;
        chk("min0_stop_serial", serial2, 1'b1);
        @(posedge Clock); #1;
        chk("min0_end_done", done2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
